// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU behind a valid/ready request/response pair.
// Ports: clk, rst_n, req_{valid,ready,a,b,control}, rsp_{valid,ready,dout,cout}.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_dout,
  output logic             rsp_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 cout_q, cout_d;

  logic                 accept;
  logic                 last;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_sum;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     res;
  logic                 res_c;

  assign accept = req_valid && req_ready;
  assign last   = (cnt_q == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is forced low for as long as reset is held
  always_comb begin
    req_ready = (state_q == IDLE) && rst_n;
    rsp_valid = (state_q == DONE);
  end

  // One iteration step and the final result
  always_comb begin
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    // Multiply: hi half accumulates a, whole acc shifts right;
    // the multiplier sits in the low half and is consumed lsb first.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_step = acc_q;
    if (ctrl_q == OP_MUL)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (ctrl_q == OP_SLL && b_q[4:0] != 5'd0)
      acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
    res   = '0;
    res_c = 1'b0;
    unique case (ctrl_q)
      OP_ADD: begin
        res   = add_sum[WIDTH-1:0];
        res_c = add_sum[WIDTH];
      end
      OP_SUB: begin
        res   = sub_sum[WIDTH-1:0];
        res_c = sub_sum[WIDTH];
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SLT: res = {{(WIDTH-1){1'b0}},
                     ($signed(a_q) < $signed(b_q))};
      OP_SLL: res = acc_step[WIDTH-1:0];
      OP_MUL: begin
        res   = acc_step[WIDTH-1:0];
        res_c = |acc_step[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    cout_d = cout_q;
    unique case (state_q)
      IDLE: if (accept) begin
        a_d    = req_a;
        b_d    = req_b;
        ctrl_d = req_control;
        acc_d  = '0;
        cnt_d  = CW'(1);
        if (req_control == OP_MUL) begin
          acc_d = {{WIDTH{1'b0}}, req_b};
          cnt_d = CW'(WIDTH);
        end else if (req_control == OP_SLL) begin
          acc_d = {{WIDTH{1'b0}}, req_a};
          // zero shift still spends one busy cycle
          if (req_b[4:0] != 5'd0) cnt_d = CW'(req_b[4:0]);
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          dout_d = res;
          cout_d = res_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      cout_q <= cout_d;
    end
  end

  assign rsp_dout = dout_q;
  assign rsp_cout = cout_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed corner cases plus random ops vs an arithmetic model.
// Drives on negedge, samples 1ns after posedge.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_control;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dout;
  logic        rsp_cout;

  int n_chk = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_control (req_control),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dout    (rsp_dout),
    .rsp_cout    (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands
  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a, b,
                                output logic [31:0] ed,
                                output logic ec,
                                output int el);
    logic [63:0] p;
    logic [32:0] s;
    ed = 32'd0;
    ec = 1'b0;
    el = 1;
    case (op)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        ed = s[31:0];
        ec = s[32];
      end
      3'd1: begin
        ed = a - b;
        ec = (a >= b);
      end
      3'd2: ed = a & b;
      3'd3: ed = a | b;
      3'd4: ed = a ^ b;
      3'd5: ed = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin
        ed = a << b[4:0];
        el = (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
      end
      default: begin
        p  = {32'd0, a} * {32'd0, b};
        ed = p[31:0];
        ec = (p[63:32] != 32'd0);
        el = 32;
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [31:0] ed;
    logic        ec;
    int          el;
    int          n;
    model(op, a, b, ed, ec, el);
    @(negedge clk);
    req_valid   = 1'b1;
    req_a       = a;
    req_b       = b;
    req_control = op;
    @(posedge clk);
    #1;
    // operands must already be captured
    req_valid   = 1'($urandom_range(0, 1));
    req_a       = $urandom;
    req_b       = $urandom;
    req_control = 3'($urandom_range(0, 7));
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(el));
    chk("dout", rsp_dout, ed);
    chk("cout", 32'(rsp_cout), 32'(ec));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = ~req_valid;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_dout", rsp_dout, ed);
      chk("hold_cout", 32'(rsp_cout), 32'(ec));
    end
    // release; a request held on the same edge must not be taken
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", 32'(rsp_valid), 32'd0);
    chk("rel_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_control = '0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dout", rsp_dout, 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(3'd1, 32'h0000_0005, 32'h0000_0007, 0);
    run_op(3'd5, 32'h0000_0005, 32'h0000_0007, 0);
    run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(3'd7, 32'h0000_0003, 32'h0000_0005, 0);
    run_op(3'd6, 32'h0000_0001, 32'h0000_001F, 0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    run_op(3'd6, 32'h8000_0001, 32'hFFFF_FFE1, 0);
    run_op(3'd5, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(3'd1, 32'h0000_0007, 32'h0000_0007, 0);
    run_op(3'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 10);

    for (int k = 0; k < 40; k++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3));

    // reset in the middle of a multiply
    @(negedge clk);
    req_valid   = 1'b1;
    req_a       = 32'h1234_5678;
    req_b       = 32'h9ABC_DEF0;
    req_control = 3'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_dout", rsp_dout, 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle", 32'(req_ready), 32'd1);
    chk("abort_norsp", 32'(rsp_valid), 32'd0);
    run_op(3'd0, 32'd2, 32'd3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
